// File: rtl/trena_pkg.sv
// rtl/trena_pkg.sv - shared FSM encoding and timing defaults for the echo trigger block
package trena_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_TRIG_CYC    = 10;
    localparam int DEF_TIMEOUT_CYC = 30000;
    localparam int DEF_HOLDOFF_CYC = 60000;
    localparam int DEF_CNT_W       = 16;

    // channel index width, never narrower than one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a bus of independent asynchronous bits
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/echo_trigger_multi.sv
// rtl/echo_trigger_multi.sv - round-robin ultrasonic trigger and echo-width measurement
module echo_trigger_multi
    import trena_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    ena,
    input  logic                    cont,
    input  logic                    start,
    input  logic [N_CH-1:0]         echo,
    output logic [N_CH-1:0]         trig,
    output logic                    busy,
    output logic                    valid,
    output logic [ch_w(N_CH)-1:0]   ch_id,
    output logic [CNT_W-1:0]        width,
    output logic                    tmo
);

    localparam int CH_W = ch_w(N_CH);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [N_CH-1:0]   echo_s;
    logic [N_CH-1:0]   echo_prev_q;
    logic              valid_q, valid_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CH_W-1:0]   ch_id_q, ch_id_d;
    logic              echo_cur;
    logic              echo_rise;

    sync2 #(.W(N_CH)) u_sync (
        .clk (clk),
        .clr (clr),
        .d   (echo),
        .q   (echo_s)
    );

    // previous level is kept for every line, so an echo already high when a channel
    // becomes current never looks like a fresh rising edge
    assign echo_cur  = echo_s[cur_ch_q];
    assign echo_rise = echo_cur & ~echo_prev_q[cur_ch_q];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_ch_q    <= '0;
            echo_prev_q <= '0;
            valid_q     <= 1'b0;
            tmo_q       <= 1'b0;
            width_q     <= '0;
            ch_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_ch_q    <= cur_ch_d;
            echo_prev_q <= echo_s;
            valid_q     <= valid_d;
            tmo_q       <= tmo_d;
            width_q     <= width_d;
            ch_id_q     <= ch_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_ch_d = cur_ch_q;
        valid_d  = 1'b0;
        tmo_d    = tmo_q;
        width_d  = width_q;
        ch_id_d  = ch_id_q;
        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cont || start) begin
                        state_d = ST_TRIG;
                        cnt_d   = '0;
                    end
                end
                ST_TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        state_d = ST_WAIT_RISE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_RISE: begin
                    if (echo_rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        tmo_d   = 1'b1;
                        width_d = '0;
                        ch_id_d = cur_ch_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (!echo_cur) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        tmo_d   = 1'b0;
                        width_d = cnt_q;
                        ch_id_d = cur_ch_q;
                    end else if (cnt_q == TMO_LAST) begin
                        // the count would reach TIMEOUT_CYC this cycle: report it saturated
                        state_d = ST_HOLDOFF;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        tmo_d   = 1'b1;
                        width_d = TMO_VAL;
                        ch_id_d = cur_ch_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d    = '0;
                        cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);
                        state_d  = cont ? ST_TRIG : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        trig = '0;
        if (state_q == ST_TRIG) begin
            trig[cur_ch_q] = 1'b1;
        end
        busy = (state_q != ST_IDLE);
    end

    assign valid = valid_q;
    assign tmo   = tmo_q;
    assign width = width_q;
    assign ch_id = ch_id_q;

endmodule

// File: tb/tb_echo_trigger_multi.sv
// tb/tb_echo_trigger_multi.sv - scoreboard bench for echo_trigger_multi
module tb_echo_trigger_multi;

    logic        clk = 1'b0;
    logic        clr;
    logic        ena;
    logic        cont;
    logic        start;
    logic [1:0]  echo;
    logic [1:0]  trig;
    logic        busy;
    logic        valid;
    logic [0:0]  ch_id;
    logic [15:0] width;
    logic        tmo;

    typedef struct {
        int ch;
        int w;
        int t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_trig;
    int   n_bad;

    echo_trigger_multi #(
        .N_CH        (2),
        .TRIG_CYC    (10),
        .TIMEOUT_CYC (100),
        .HOLDOFF_CYC (20),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .ena   (ena),
        .cont  (cont),
        .start (start),
        .echo  (echo),
        .trig  (trig),
        .busy  (busy),
        .valid (valid),
        .ch_id (ch_id),
        .width (width),
        .tmo   (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clr === 1'b1 && valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got strobe ch_id=%0d width=%0d tmo=%0d, expected none",
                         ch_id, width, tmo);
            end else begin
                mon_e = sb.pop_front();
                chk("res_ch_id", 32'(ch_id), mon_e.ch);
                chk("res_width", 32'(width), mon_e.w);
                chk("res_tmo",   32'(tmo),   mon_e.t);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic count_trig(input int ch, output int n, output int bad);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (trig[ch]) n++;
            if (trig[1-ch]) bad++;
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (busy !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(busy), 0);
    endtask

    task automatic wait_sb(input string name, input int max);
        int k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic echo_pulse(input int ch, input int lead, input int len);
        repeat (lead) @(posedge clk);
        #1 echo[ch] = 1'b1;
        repeat (len) @(posedge clk);
        #1 echo[ch] = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b0; ena = 1'b0; cont = 1'b0; start = 1'b0; echo = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trig",  32'(trig),  0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_width", 32'(width), 0);
        chk("rst_ch_id", 32'(ch_id), 0);
        chk("rst_tmo",   32'(tmo),   0);
        @(posedge clk); #1 clr = 1'b1; ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_trig", 32'(trig), 0);

        // single shot on ch0, 37-cycle echo
        pulse_start();
        count_trig(0, n_trig, n_bad);
        chk("t34_trig_len", n_trig, 10);
        chk("t34_trig_other", n_bad, 0);
        sb.push_back('{0, 37, 0});
        echo_pulse(0, 1, 37);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t34_valid_early", 32'(valid), 0);
        @(negedge clk);
        chk("t34_valid_lat3", 32'(valid), 1);
        repeat (19) @(negedge clk);
        chk("t34_holdoff_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t34_idle_after_holdoff", 32'(busy), 0);

        // ch1 with echo already high on entry, plus ch0 noise: times out
        @(posedge clk); #1 echo[1] = 1'b1;
        sb.push_back('{1, 0, 1});
        pulse_start();
        count_trig(1, n_trig, n_bad);
        chk("t29_trig_len", n_trig, 10);
        chk("t29_trig_other", n_bad, 0);
        echo_pulse(1, 0, 0);
        echo_pulse(0, 5, 10);
        wait_idle("t29_idle", 300);

        // ch0 echo held 150 cycles: saturates at the timeout
        sb.push_back('{0, 100, 1});
        pulse_start();
        echo_pulse(0, 20, 150);
        wait_idle("t36_idle", 200);

        // continuous ranging with no echoes, starting from ch0 after reset
        @(posedge clk); #1 clr = 1'b0;
        #2 clr = 1'b1;
        @(posedge clk); #1 cont = 1'b1;
        sb.push_back('{0, 0, 1});
        sb.push_back('{1, 0, 1});
        sb.push_back('{0, 0, 1});
        wait_sb("t35_three_results", 600);
        @(posedge clk); #1 cont = 1'b0;
        wait_idle("t35_idle", 100);

        // ena dropped mid-measure on ch1
        pulse_start();
        count_trig(1, n_trig, n_bad);
        chk("t37_trig_len", n_trig, 10);
        @(posedge clk); #1 echo[1] = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t37_busy_measuring", 32'(busy), 1);
        @(posedge clk); #1 ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t37_busy_off", 32'(busy), 0);
        chk("t37_trig_off", 32'(trig), 0);
        chk("t37_no_valid", 32'(valid), 0);
        repeat (10) @(posedge clk);
        #1 echo[1] = 1'b0; ena = 1'b1;
        repeat (10) @(negedge clk);
        chk("t37_stay_idle", 32'(busy), 0);

        // cur_ch retained at 1: short pulse on ch1
        sb.push_back('{1, 5, 0});
        pulse_start();
        echo_pulse(1, 20, 5);
        wait_idle("t38_pre_idle", 200);

        // async clear during trigger on ch0
        pulse_start();
        repeat (3) @(negedge clk);
        chk("t38_trig_ch0", 32'(trig), 1);
        #1 clr = 1'b0;
        #1;
        chk("t38_clr_trig",  32'(trig),  0);
        chk("t38_clr_busy",  32'(busy),  0);
        chk("t38_clr_valid", 32'(valid), 0);
        chk("t38_clr_width", 32'(width), 0);
        chk("t38_clr_ch_id", 32'(ch_id), 0);
        chk("t38_clr_tmo",   32'(tmo),   0);
        @(posedge clk); #1 clr = 1'b1;
        repeat (5) @(negedge clk);
        chk("t38_no_trig_after_clr", 32'(trig), 0);
        chk("t38_idle_after_clr", 32'(busy), 0);

        // echo1 pulse while ch0 is current is ignored
        sb.push_back('{0, 0, 1});
        pulse_start();
        echo_pulse(1, 20, 10);
        wait_idle("t38_ignore_idle", 300);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_trigger_multi.md
ECHO_TRIGGER_MULTI -- requirements
Module: echo_trigger_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of ultrasonic sensor channels (1..8).
REQ-002 SHALL have parameter TRIG_CYC, default 10, trigger pulse width in clk cycles (10 us at 1 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 30000, maximum wait/measure time per phase in clk cycles.
REQ-004 SHALL have parameter HOLDOFF_CYC, default 60000, quiet time after each measurement before the next trigger.
REQ-005 SHALL have parameter CNT_W, default 16, width of counters and result; CNT_W SHALL hold max(TIMEOUT_CYC, HOLDOFF_CYC).
REQ-006 SHALL have port clk  input  1  clock, 1 MHz, rising edge.
REQ-007 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port ena  input  1  synchronous enable; low aborts and holds the block idle.
REQ-009 SHALL have port cont  input  1  1 = continuous round-robin ranging, 0 = single-shot on start.
REQ-010 SHALL have port start  input  1  single-cycle request for one measurement on the current channel.
REQ-011 SHALL have port echo  input  N_CH  asynchronous echo lines from sensors.
REQ-012 SHALL have port trig  output  N_CH  trigger lines, at most one bit high.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port valid  output  1  one-cycle strobe qualifying result outputs.
REQ-015 SHALL have port ch_id  output  $clog2(N_CH) (min 1)  channel of the result.
REQ-016 SHALL have port width  output  CNT_W  echo high time in clk cycles.
REQ-017 SHALL have port tmo  output  1  result is a timeout.

Function
REQ-018 SHALL implement FSM states IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-019 IDLE -> TRIG when ena=1 and (cont=1 or start=1); start while busy SHALL be ignored.
REQ-020 TRIG SHALL drive trig[cur_ch] high for exactly TRIG_CYC cycles, then enter WAIT_RISE.
REQ-021 WAIT_RISE SHALL enter MEASURE on synchronised echo[cur_ch] rising edge; after TIMEOUT_CYC cycles without it SHALL strobe valid with tmo=1, width=0, and enter HOLDOFF.
REQ-022 MEASURE SHALL increment width counter each cycle echo is high; on falling edge SHALL strobe valid with tmo=0 and the count, then HOLDOFF.
REQ-023 MEASURE reaching TIMEOUT_CYC SHALL strobe valid with tmo=1, width=TIMEOUT_CYC, then HOLDOFF; counter never wraps.
REQ-024 HOLDOFF SHALL last HOLDOFF_CYC cycles, then advance cur_ch (N_CH-1 wraps to 0) and enter TRIG if cont=1, else IDLE.
REQ-025 echo SHALL pass a 2-flop synchroniser; valid SHALL assert 3 cycles after the asynchronous echo falling edge.
REQ-026 Echo on channels other than cur_ch SHALL be ignored.
REQ-027 ena=0 in any state SHALL, next cycle, force trig to 0, state to IDLE, suppress valid; cur_ch SHALL be retained.
REQ-028 width, ch_id, tmo SHALL hold their last value between strobes.
REQ-029 echo already high on entry to WAIT_RISE SHALL not count as a rising edge.

Reset
REQ-030 clr=0 SHALL set state IDLE, cur_ch 0, all counters 0, trig 0, busy 0, valid 0, width 0, ch_id 0, tmo 0, synchroniser flops 0.
REQ-031 Reset deassertion SHALL not produce a trigger until the first qualifying clk edge with ena=1.

Structure
REQ-032 FSM state encoding and default timing constants SHALL reside in shared package trena_pkg.
REQ-033 The synchroniser SHALL be sub-module sync2 (parametrised width), instantiated once for N_CH bits.

Verification (N_CH=2, TRIG_CYC=10, TIMEOUT_CYC=100, HOLDOFF_CYC=20)
REQ-034 cont=0, start pulse, echo0 high 37 cycles -> trig[0] high 10 cycles, valid once, width=37, ch_id=0, tmo=0, IDLE after 20-cycle holdoff.
REQ-035 cont=1, no echo -> valid tmo=1 width=0 ch_id=0, then ch_id=1, then ch_id=0 (wrap).
REQ-036 echo0 held high 150 cycles -> valid tmo=1 width=100.
REQ-037 ena dropped mid-MEASURE -> trig 0, busy 0 next cycle, no valid.
REQ-038 clr asserted mid-TRIG -> all outputs 0 immediately; echo1 pulse while cur_ch=0 -> ignored.
